// File: rtl/sdram_cmd_scheduler_pkg.sv
// Shared command codes, transaction owners and burst geometry for the SDRAM command scheduler.
package sdram_cmd_scheduler_pkg;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_WR256 = 2'b01;
  localparam logic [1:0] CMD_RD32  = 2'b10;
  localparam logic [1:0] CMD_RD256 = 2'b11;

  localparam int VID_BEATS   = 16;
  localparam int CACHE_BEATS = 128;

  localparam logic [7:0] VID_PREFIX = 8'b1000_0000;

  typedef enum logic [1:0] {OWN_VID, OWN_WR, OWN_RD} owner_e;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER} state_e;

  function automatic logic [1:0] owner_cmd(input owner_e o);
    case (o)
      OWN_VID: return CMD_RD32;
      OWN_WR:  return CMD_WR256;
      default: return CMD_RD256;
    endcase
  endfunction

  // Index of the final beat; 128 beats end at 127, which still fits the 7-bit counter.
  function automatic logic [6:0] last_beat_idx(input owner_e o);
    if (o == OWN_VID) return 7'(VID_BEATS - 1);
    return 7'(CACHE_BEATS - 1);
  endfunction

endpackage

// File: rtl/sdram_beat_counter.sv
// Counts data beats of the active burst and packs 16-bit video beats into 32-bit queue writes.
module sdram_beat_counter
  import sdram_cmd_scheduler_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        active,
  input  logic        pack_en,
  input  logic        beat,
  input  logic [6:0]  last_idx,
  input  logic [15:0] din,
  output logic        last_beat,
  output logic        vq_we,
  output logic [31:0] vq_din
);

  logic [6:0]  cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic [15:0] low_q, low_d;
  logic        vq_we_q, vq_we_d;
  logic [31:0] vq_din_q, vq_din_d;

  always_comb begin
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    low_d     = low_q;
    vq_we_d   = 1'b0;
    vq_din_d  = vq_din_q;
    last_beat = active && beat && (cnt_q == last_idx);
    if (clear) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (active && beat) begin
      cnt_d = cnt_q + 7'd1;
      if (pack_en) begin
        phase_d = ~phase_q;
        if (!phase_q) begin
          low_d = din;
        end else begin
          vq_we_d  = 1'b1;
          vq_din_d = {din, low_q};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      low_q    <= '0;
      vq_we_q  <= 1'b0;
      vq_din_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      low_q    <= low_d;
      vq_we_q  <= vq_we_d;
      vq_din_q <= vq_din_d;
    end
  end

  assign vq_we  = vq_we_q;
  assign vq_din = vq_din_q;

endmodule

// File: rtl/sdram_cmd_scheduler.sv
// Arbitrates video refills against cache line traffic, issues one SDRAM command at a time
// and tracks the burst until its last beat; cache requests are forced through after STARVE_MAX video grants.
module sdram_cmd_scheduler
  import sdram_cmd_scheduler_pkg::*;
#(
  parameter int VID_WORDS  = 1200,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vid_low,
  input  logic        cache_wr_req,
  input  logic        cache_rd_req,
  input  logic [16:0] cache_waddr,
  input  logic [16:0] cache_raddr,
  output logic [1:0]  sys_cmd,
  output logic [22:0] sys_addr,
  input  logic [1:0]  sys_cmd_ack,
  input  logic        sys_rd_data_valid,
  input  logic        sys_wr_data_valid,
  input  logic [15:0] sys_dout,
  output logic        vq_we,
  output logic [31:0] vq_din,
  output logic        cache_fill,
  output logic        cache_drain,
  output logic        busy,
  output logic        frame_wrap
);

  localparam int              SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [11:0]     VID_LAST   = 12'(VID_WORDS - 1);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [22:0]   addr_q, addr_d;
  logic [11:0]   vidadr_q, vidadr_d;
  logic [SW-1:0] starve_q, starve_d;

  logic   cache_pend, ack_hit, xfer, beat, last_beat;
  owner_e grant_owner;

  assign cache_pend = cache_wr_req | cache_rd_req;
  assign ack_hit    = (state_q == ST_REQ) && (sys_cmd_ack == cmd_q);
  assign xfer       = (state_q == ST_XFER);
  assign beat       = (owner_q == OWN_WR) ? sys_wr_data_valid : sys_rd_data_valid;

  // Cache wins outright when video is not asking, or when video has starved it long enough.
  always_comb begin
    grant_owner = OWN_VID;
    if (cache_pend && (!vid_low || starve_q == STARVE_LIM)) begin
      grant_owner = cache_wr_req ? OWN_WR : OWN_RD;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    vidadr_d   = vidadr_q;
    starve_d   = starve_q;
    frame_wrap = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (vid_low || cache_pend) begin
          owner_d = grant_owner;
          cmd_d   = owner_cmd(grant_owner);
          state_d = ST_REQ;
          case (grant_owner)
            OWN_VID: begin
              addr_d = {VID_PREFIX, vidadr_q, 3'b000};
              if (cache_pend && starve_q != STARVE_LIM) starve_d = starve_q + 1'b1;
            end
            OWN_WR: begin
              addr_d   = {cache_waddr, 6'b0};
              starve_d = '0;
            end
            default: begin
              addr_d   = {cache_raddr, 6'b0};
              starve_d = '0;
            end
          endcase
        end
      end
      ST_REQ: begin
        if (ack_hit) begin
          cmd_d   = CMD_NOP;
          state_d = ST_XFER;
          if (owner_q == OWN_VID) begin
            if (vidadr_q == VID_LAST) begin
              vidadr_d   = '0;
              frame_wrap = !rst;
            end else begin
              vidadr_d = vidadr_q + 12'd1;
            end
          end
        end
      end
      ST_XFER: begin
        if (last_beat) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_VID;
      cmd_q    <= CMD_NOP;
      addr_q   <= '0;
      vidadr_q <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      vidadr_q <= vidadr_d;
      starve_q <= starve_d;
    end
  end

  sdram_beat_counter u_beat (
    .clk       (clk),
    .rst       (rst),
    .clear     (ack_hit),
    .active    (xfer),
    .pack_en   (owner_q == OWN_VID),
    .beat      (beat),
    .last_idx  (last_beat_idx(owner_q)),
    .din       (sys_dout),
    .last_beat (last_beat),
    .vq_we     (vq_we),
    .vq_din    (vq_din)
  );

  assign sys_cmd     = cmd_q;
  assign sys_addr    = addr_q;
  assign busy        = (state_q != ST_IDLE);
  assign cache_fill  = !rst && xfer && (owner_q == OWN_RD) && sys_rd_data_valid;
  assign cache_drain = !rst && xfer && (owner_q == OWN_WR) && sys_wr_data_valid;

endmodule

// File: tb/tb_sdram_cmd_scheduler.sv
// Directed bench for sdram_cmd_scheduler: arbitration, handshake, beat counting, packing, wrap and reset.
module tb_sdram_cmd_scheduler;

  logic        clk;
  logic        rst;
  logic        vid_low;
  logic        cache_wr_req;
  logic        cache_rd_req;
  logic [16:0] cache_waddr;
  logic [16:0] cache_raddr;
  logic [1:0]  sys_cmd;
  logic [22:0] sys_addr;
  logic [1:0]  sys_cmd_ack;
  logic        sys_rd_data_valid;
  logic        sys_wr_data_valid;
  logic [15:0] sys_dout;
  logic        vq_we;
  logic [31:0] vq_din;
  logic        cache_fill;
  logic        cache_drain;
  logic        busy;
  logic        frame_wrap;

  int checks = 0;
  int errors = 0;

  sdram_cmd_scheduler #(.VID_WORDS(1200), .STARVE_MAX(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .vid_low           (vid_low),
    .cache_wr_req      (cache_wr_req),
    .cache_rd_req      (cache_rd_req),
    .cache_waddr       (cache_waddr),
    .cache_raddr       (cache_raddr),
    .sys_cmd           (sys_cmd),
    .sys_addr          (sys_addr),
    .sys_cmd_ack       (sys_cmd_ack),
    .sys_rd_data_valid (sys_rd_data_valid),
    .sys_wr_data_valid (sys_wr_data_valid),
    .sys_dout          (sys_dout),
    .vq_we             (vq_we),
    .vq_din            (vq_din),
    .cache_fill        (cache_fill),
    .cache_drain       (cache_drain),
    .busy              (busy),
    .frame_wrap        (frame_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    vid_low = 0; cache_wr_req = 0; cache_rd_req = 0;
    sys_cmd_ack = 0; sys_rd_data_valid = 0; sys_wr_data_valid = 0; sys_dout = 0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Drives n data beats (dout = 1..n) and tallies the strobes the DUT produces.
  task automatic run_beats(input int n, input bit wr, output int fills, output int drains,
                           output int vqs, output logic [31:0] first_din, output logic [31:0] last_din);
    fills = 0; drains = 0; vqs = 0; first_din = '0; last_din = '0;
    for (int i = 1; i <= n; i++) begin
      if (wr) sys_wr_data_valid = 1'b1;
      else    sys_rd_data_valid = 1'b1;
      sys_dout = 16'(i);
      #1;
      if (cache_fill)  fills++;
      if (cache_drain) drains++;
      tick;
      if (vq_we) begin
        if (vqs == 0) first_din = vq_din;
        last_din = vq_din;
        vqs++;
      end
    end
    sys_wr_data_valid = 1'b0;
    sys_rd_data_valid = 1'b0;
  endtask

  // Waits for an issued command, acks it, and completes its burst.
  task automatic serve(output logic [1:0] cmd, output logic [22:0] addr, output bit wrap,
                       output int fills, output int drains, output int vqs);
    int waited;
    logic [31:0] d0, d1;
    waited = 0;
    fills = 0; drains = 0; vqs = 0; wrap = 1'b0;
    while (sys_cmd == 2'b00 && waited < 20) begin
      tick;
      waited++;
    end
    cmd  = sys_cmd;
    addr = sys_addr;
    if (sys_cmd == 2'b00) begin
      checks++; errors++;
      $display("FAIL serve_timeout: sys_cmd=%0d required nonzero within 20 cycles", sys_cmd);
    end else begin
      sys_cmd_ack = sys_cmd;
      #1;
      wrap = frame_wrap;
      tick;
      sys_cmd_ack = 2'b00;
      run_beats((cmd == 2'b10) ? 16 : 128, cmd == 2'b01, fills, drains, vqs, d0, d1);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    sys_rd_data_valid = 1'b1;
    sys_wr_data_valid = 1'b1;
    tick;
    tick;
    checks++; if (sys_cmd !== 2'b00) begin errors++; $display("FAIL reset_cmd: got %0d want 0", sys_cmd); end
    checks++; if (sys_addr !== 23'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", sys_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (vq_we !== 1'b0 || vq_din !== 32'h0) begin errors++; $display("FAIL reset_vq: we=%b din=%h want 0/0", vq_we, vq_din); end
    checks++; if (frame_wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b want 0", frame_wrap); end
    checks++; if (cache_fill !== 1'b0 || cache_drain !== 1'b0) begin errors++; $display("FAIL reset_fill_drain: fill=%b drain=%b want 0/0", cache_fill, cache_drain); end
    do_reset;
  endtask

  task automatic test_video_burst;
    int f, d, v;
    logic [31:0] d0, d1;
    do_reset;
    vid_low = 1'b1;
    tick;
    vid_low = 1'b0;
    checks++; if (sys_cmd !== 2'b10) begin errors++; $display("FAIL vid_cmd: got %0d want 2", sys_cmd); end
    checks++; if (sys_addr !== 23'h400000) begin errors++; $display("FAIL vid_addr: got %h want 400000", sys_addr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL vid_busy: got %b want 1", busy); end
    repeat (3) tick;
    checks++; if (sys_cmd !== 2'b10 || sys_addr !== 23'h400000) begin errors++; $display("FAIL vid_hold: cmd=%0d addr=%h want 2/400000", sys_cmd, sys_addr); end
    sys_cmd_ack = 2'b10;
    tick;
    sys_cmd_ack = 2'b00;
    checks++; if (sys_cmd !== 2'b00 || busy !== 1'b1) begin errors++; $display("FAIL vid_xfer_entry: cmd=%0d busy=%b want 0/1", sys_cmd, busy); end
    run_beats(16, 1'b0, f, d, v, d0, d1);
    checks++; if (v != 8) begin errors++; $display("FAIL vid_vq_count: got %0d want 8", v); end
    checks++; if (d0 !== 32'h00020001) begin errors++; $display("FAIL vid_first_din: got %h want 00020001", d0); end
    checks++; if (d1 !== 32'h0010000F) begin errors++; $display("FAIL vid_last_din: got %h want 0010000f", d1); end
    checks++; if (busy !== 1'b0 || f != 0) begin errors++; $display("FAIL vid_done: busy=%b fills=%0d want 0/0", busy, f); end
  endtask

  task automatic test_starvation;
    logic [1:0]  exp_cmd  [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
    logic [22:0] exp_addr [6] = '{23'h400000, 23'h400008, 23'h400010, 23'h400018, 23'h0048C0, 23'h400020};
    logic [1:0]  c;
    logic [22:0] a;
    bit w;
    int f, d, v;
    do_reset;
    cache_waddr = 17'h00123;
    cache_raddr = 17'h00456;
    vid_low = 1'b1; cache_wr_req = 1'b1; cache_rd_req = 1'b1;
    for (int g = 0; g < 6; g++) begin
      serve(c, a, w, f, d, v);
      checks++; if (c !== exp_cmd[g]) begin errors++; $display("FAIL starve_cmd[%0d]: got %0d want %0d", g, c, exp_cmd[g]); end
      checks++; if (a !== exp_addr[g]) begin errors++; $display("FAIL starve_addr[%0d]: got %h want %h", g, a, exp_addr[g]); end
      if (g == 4) begin
        checks++; if (d != 128) begin errors++; $display("FAIL starve_drains: got %0d want 128", d); end
      end
    end
    vid_low = 1'b0; cache_wr_req = 1'b0; cache_rd_req = 1'b0;
    tick;
  endtask

  task automatic test_cache_read;
    logic [1:0]  c;
    logic [22:0] a;
    bit w;
    int f, d, v;
    do_reset;
    cache_raddr = 17'h1ABCD;
    cache_rd_req = 1'b1;
    tick;
    cache_rd_req = 1'b0;
    checks++; if (sys_cmd !== 2'b11) begin errors++; $display("FAIL rd_cmd: got %0d want 3", sys_cmd); end
    checks++; if (sys_addr !== 23'h6AF340) begin errors++; $display("FAIL rd_addr: got %h want 6af340", sys_addr); end
    serve(c, a, w, f, d, v);
    checks++; if (f != 128) begin errors++; $display("FAIL rd_fills: got %0d want 128", f); end
    checks++; if (busy !== 1'b0 || v != 0) begin errors++; $display("FAIL rd_done: busy=%b vq_writes=%0d want 0/0", busy, v); end
    sys_rd_data_valid = 1'b1;
    #1;
    checks++; if (cache_fill !== 1'b0) begin errors++; $display("FAIL rd_idle_fill: got %b want 0", cache_fill); end
    repeat (3) tick;
    sys_rd_data_valid = 1'b0;
    checks++; if (busy !== 1'b0 || vq_we !== 1'b0) begin errors++; $display("FAIL rd_idle_strobes: busy=%b vq_we=%b want 0/0", busy, vq_we); end
  endtask

  task automatic test_ack_mismatch;
    int f, d, v;
    logic [31:0] d0, d1;
    do_reset;
    vid_low = 1'b1;
    tick;
    vid_low = 1'b0;
    sys_cmd_ack = 2'b01;
    tick;
    checks++; if (sys_cmd !== 2'b10 || busy !== 1'b1) begin errors++; $display("FAIL mismatch_hold1: cmd=%0d busy=%b want 2/1", sys_cmd, busy); end
    tick;
    checks++; if (sys_cmd !== 2'b10) begin errors++; $display("FAIL mismatch_hold2: cmd=%0d want 2", sys_cmd); end
    sys_cmd_ack = 2'b10;
    tick;
    sys_cmd_ack = 2'b00;
    checks++; if (sys_cmd !== 2'b00 || busy !== 1'b1) begin errors++; $display("FAIL mismatch_xfer: cmd=%0d busy=%b want 0/1", sys_cmd, busy); end
    run_beats(16, 1'b0, f, d, v, d0, d1);
    checks++; if (v != 8 || busy !== 1'b0) begin errors++; $display("FAIL mismatch_burst: vq_writes=%0d busy=%b want 8/0", v, busy); end
  endtask

  task automatic test_wrap;
    logic [1:0]  c;
    logic [22:0] a;
    bit w;
    int f, d, v;
    int wraps, wrap_at;
    wraps = 0; wrap_at = 0;
    do_reset;
    vid_low = 1'b1;
    for (int b = 1; b <= 1201; b++) begin
      serve(c, a, w, f, d, v);
      if (w) begin wraps++; wrap_at = b; end
      if (b == 1200) begin
        checks++; if (a !== 23'h402578) begin errors++; $display("FAIL wrap_last_addr: got %h want 402578", a); end
      end
      if (b == 1201) begin
        checks++; if (a !== 23'h400000) begin errors++; $display("FAIL wrap_first_addr: got %h want 400000", a); end
      end
    end
    vid_low = 1'b0;
    tick;
    checks++; if (wraps != 1 || wrap_at != 1200) begin errors++; $display("FAIL wrap_pulse: count=%0d at=%0d want 1/1200", wraps, wrap_at); end
  endtask

  task automatic test_reset_mid_write;
    logic [1:0]  c;
    logic [22:0] a;
    bit w;
    int f, d, v;
    logic [31:0] d0, d1;
    do_reset;
    cache_waddr = 17'h00010;
    cache_wr_req = 1'b1;
    tick;
    cache_wr_req = 1'b0;
    checks++; if (sys_cmd !== 2'b01 || sys_addr !== 23'h000400) begin errors++; $display("FAIL wr_issue: cmd=%0d addr=%h want 1/000400", sys_cmd, sys_addr); end
    sys_cmd_ack = 2'b01;
    tick;
    sys_cmd_ack = 2'b00;
    run_beats(59, 1'b1, f, d, v, d0, d1);
    checks++; if (d != 59) begin errors++; $display("FAIL wr_drains: got %0d want 59", d); end
    sys_wr_data_valid = 1'b1;
    rst = 1'b1;
    #1;
    checks++; if (cache_drain !== 1'b0) begin errors++; $display("FAIL wr_drain_in_reset: got %b want 0", cache_drain); end
    tick;
    rst = 1'b0;
    checks++; if (sys_cmd !== 2'b00 || busy !== 1'b0 || sys_addr !== 23'h0) begin errors++; $display("FAIL wr_after_reset: cmd=%0d busy=%b addr=%h want 0/0/0", sys_cmd, busy, sys_addr); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (cache_drain !== 1'b0) begin errors++; $display("FAIL wr_stray_drain[%0d]: got %b want 0", i, cache_drain); end
      tick;
    end
    sys_wr_data_valid = 1'b0;
    cache_wr_req = 1'b1;
    tick;
    cache_wr_req = 1'b0;
    serve(c, a, w, f, d, v);
    checks++; if (c !== 2'b01 || d != 128 || busy !== 1'b0) begin errors++; $display("FAIL wr_fresh: cmd=%0d drains=%0d busy=%b want 1/128/0", c, d, busy); end
  endtask

  initial begin
    rst = 1'b1;
    vid_low = 0; cache_wr_req = 0; cache_rd_req = 0;
    cache_waddr = 0; cache_raddr = 0;
    sys_cmd_ack = 0; sys_rd_data_valid = 0; sys_wr_data_valid = 0; sys_dout = 0;
    test_reset;
    test_video_burst;
    test_starvation;
    test_cache_read;
    test_ack_mismatch;
    test_reset_mid_write;
    test_wrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_cmd_scheduler.md
SDRAM_CMD_SCHEDULER -- requirements
Module: sdram_cmd_scheduler

Interface
REQ-001 The block SHALL have parameter VID_WORDS, default 1200, meaning the number of 32-byte video bursts per frame; the address wraps at VID_WORDS-1.
REQ-002 The block SHALL have parameter STARVE_MAX, default 4, meaning the maximum consecutive video grants while a cache request waits.
REQ-003 The block SHALL have port clk, input, 1 bit: the sole clock (the SDRAM clock domain).
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port vid_low, input, 1 bit: the video queue is almost empty.
REQ-006 The block SHALL have port cache_wr_req, input, 1 bit: the cache requests a 256-byte write-back.
REQ-007 The block SHALL have port cache_rd_req, input, 1 bit: the cache requests a 256-byte line fill.
REQ-008 The block SHALL have port cache_waddr, input, 17 bits: the write-back line address.
REQ-009 The block SHALL have port cache_raddr, input, 17 bits: the fill line address.
REQ-010 The block SHALL have port sys_cmd, output, 2 bits: the SDRAM command (00 nop, 01 write 256 B, 10 read 32 B, 11 read 256 B).
REQ-011 The block SHALL have port sys_addr, output, 23 bits: the SDRAM word address.
REQ-012 The block SHALL have port sys_cmd_ack, input, 2 bits: the controller acknowledges, echoing the command code.
REQ-013 The block SHALL have ports sys_rd_data_valid and sys_wr_data_valid, input, 1 bit each: per-halfword beat strobes.
REQ-014 The block SHALL have port sys_dout, input, 16 bits: SDRAM read data.
REQ-015 The block SHALL have ports vq_we (output, 1 bit) and vq_din (output, 32 bits): the video queue write strobe and data.
REQ-016 The block SHALL have ports cache_fill (output, 1 bit) and cache_drain (output, 1 bit): cache data strobes.
REQ-017 The block SHALL have ports busy (output, 1 bit) and frame_wrap (output, 1 bit): the transaction-in-flight flag and the 1-cycle pulse on video address wrap.

Function
REQ-018 The FSM SHALL have states IDLE, REQ and XFER; busy SHALL be 1 exactly when the state is not IDLE.
REQ-019 In IDLE, arbitration SHALL use fixed priority vid_low > cache_wr_req > cache_rd_req.
REQ-020 Exception to REQ-019: when starve_cnt == STARVE_MAX and any cache request is pending, the cache request SHALL win, with write before read.
REQ-021 On a grant, the block SHALL register the owner and, in the next cycle, drive sys_cmd and sys_addr from registers, entering REQ.
REQ-022 sys_addr for video SHALL be {8'b10000000, vidadr[11:0], 3'b000}.
REQ-023 sys_addr for a write SHALL be {cache_waddr, 6'b0}, and for a read {cache_raddr, 6'b0}; the line address SHALL be sampled at grant.
REQ-024 In REQ, sys_cmd and sys_addr SHALL hold stable until sys_cmd_ack equals the issued code; the next cycle SHALL drive sys_cmd=00 and enter XFER.
REQ-025 A sys_cmd_ack value that is non-zero but does not match the issued code SHALL be ignored.
REQ-026 XFER SHALL count beats with a 7-bit counter cleared on XFER entry.
REQ-027 The video beat count SHALL be 16 sys_rd_data_valid beats; cache read SHALL be 128 sys_rd_data_valid beats; cache write SHALL be 128 sys_wr_data_valid beats.
REQ-028 The cycle of the last beat SHALL return the FSM to IDLE; a new grant is allowed from the following cycle.
REQ-029 cache_fill SHALL equal sys_rd_data_valid while in XFER with owner cache-read, and SHALL be 0 otherwise.
REQ-030 cache_drain SHALL equal sys_wr_data_valid while in XFER with owner cache-write, and SHALL be 0 otherwise.
REQ-031 Video packing: an even beat SHALL latch sys_dout as the low half; an odd beat SHALL pulse vq_we for 1 cycle with vq_din={sys_dout, low}.
REQ-032 The packing phase SHALL clear on XFER entry, giving 8 queue writes per video burst.
REQ-033 vidadr SHALL advance on the video ack cycle; VID_WORDS-1 SHALL wrap to 0, with frame_wrap pulsed in that cycle.
REQ-034 starve_cnt SHALL increment on each video grant while a cache request is pending, saturate at STARVE_MAX, and clear on any cache grant.
REQ-035 Data-valid strobes outside XFER SHALL be ignored: no vq_we, cache_fill or cache_drain, and no counter change.
REQ-036 A request deasserted after grant SHALL NOT abort the transaction.

Reset
REQ-037 rst SHALL force IDLE, sys_cmd=00, sys_addr=0, vq_we=0, vq_din=0, busy=0 and frame_wrap=0.
REQ-038 rst SHALL clear vidadr, the beat counter, the packing phase and starve_cnt; it takes effect in any state, including mid-XFER.
REQ-039 cache_fill and cache_drain SHALL be 0 during and after reset until the next XFER.

Structure
REQ-040 A shared package SHALL hold the command codes (NOP/WR256/RD32/RD256), the owner enum, the beat counts 16/128 and the video base prefix 8'b10000000.
REQ-041 The beat counter and packing logic SHALL form one natural sub-module, sdram_beat_counter; the rest SHALL be flat.

Verification
REQ-042 The bench SHALL cover: vid_low=1 alone -> sys_cmd=10, sys_addr=0x400000, held until ack=10; 16 rd beats 0x0001..0x0010 -> 8 vq_we pulses, first vq_din=0x00020001.
REQ-043 The bench SHALL cover: vid_low, cache_wr_req and cache_rd_req asserted together -> grant order video, video, video, video, write (STARVE_MAX=4), with vid_low held high throughout.
REQ-044 The bench SHALL cover: cache_rd_req with cache_raddr=0x1ABCD -> sys_addr=0x6AF340, sys_cmd=11, and exactly 128 cache_fill pulses before busy falls.
REQ-045 The bench SHALL cover: 1200 video bursts -> vidadr wraps to 0 and frame_wrap pulses once, on the 1200th ack.
REQ-046 The bench SHALL cover: rst asserted at the 60th write beat -> next cycle IDLE, sys_cmd=00, busy=0; subsequent wr_valid strobes -> cache_drain stays 0.
REQ-047 The bench SHALL cover: ack=01 while RD32 is pending -> command held, no XFER entry; ack=10 -> XFER entered.
